siso_word_transfer_controller: RTL and testbench

//  Sequences a DATA_WIDTH-bit serial-in/serial-out shift register as a word-level delay-line transfer engine.
//  - Accepts a parallel word via valid/ready and serialises it MSB-first into the SISO (FILL).
//  - Shifts zeros in while capturing the SISO serial output back into a parallel word (FLUSH).
//  - Presents the captured word via valid/ready.
//  - Sits between a word-level producer/consumer and one SISO instance; it is the SISO's only shift/data driver.

---
 rtl/siso_word_transfer_controller.sv | 149 ++++++++++++++
 tb/tb_siso_word_transfer_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_word_transfer_controller.sv
// Word-level transfer engine for one SISO shift register: serialises a word in (FILL), shifts it back out (FLUSH).
// Optional SISO_XFER_LOOPBACK_CHECK_EN adds Mismatch_Out comparing the returned word against the sent word.
module siso_word_transfer_controller #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  In_Valid_In,
  input  logic [DATA_WIDTH-1:0] In_Data_In,
  output logic                  In_Ready_Out,
  output logic                  Out_Valid_Out,
  output logic [DATA_WIDTH-1:0] Out_Data_Out,
  input  logic                  Out_Ready_In,
  output logic                  Siso_Shift_Out,
  output logic                  Siso_Data_Out,
  input  logic                  Siso_Data_In,
  output logic                  Busy_Out
`ifdef SISO_XFER_LOOPBACK_CHECK_EN
  ,
  output logic                  Mismatch_Out
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] word, word_nxt;
  logic [DATA_WIDTH-1:0] capture, capture_nxt;
  logic                  load_out;
  logic                  hs_done;
  logic                  shift_c;
  logic                  data_c;

  // MSB-first: bit_cnt 0 addresses the top bit in both directions
  assign bit_idx = LAST_BIT - bit_cnt;

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    word_nxt    = word;
    capture_nxt = capture;
    load_out    = 1'b0;
    hs_done     = 1'b0;
    shift_c     = 1'b0;
    data_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (In_Valid_In && In_Ready_Out && Enable_In) begin
          word_nxt    = In_Data_In;
          bit_cnt_nxt = '0;
          state_nxt   = S_FILL;
        end
      end
      S_FILL: begin
        shift_c = Enable_In;
        data_c  = word[bit_idx];
        if (Enable_In) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            state_nxt   = S_FLUSH;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      S_FLUSH: begin
        shift_c = Enable_In;
        if (Enable_In) begin
          // the SISO MSB tap is sampled on the same edge that shifts a zero in
          capture_nxt[bit_idx] = Siso_Data_In;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            load_out    = 1'b1;
            state_nxt   = S_DONE;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        // consumer handshake is independent of Enable_In
        if (Out_Ready_In) begin
          hs_done   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (Reset_In) begin
      shift_c = 1'b0;
      data_c  = 1'b0;
    end
  end

  assign Siso_Shift_Out = shift_c;
  assign Siso_Data_Out  = data_c;

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      word          <= '0;
      capture       <= '0;
      Out_Data_Out  <= '0;
      In_Ready_Out  <= 1'b1;
      Out_Valid_Out <= 1'b0;
      Busy_Out      <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      word          <= word_nxt;
      capture       <= capture_nxt;
      In_Ready_Out  <= (state_nxt == S_IDLE);
      Out_Valid_Out <= (state_nxt == S_DONE);
      Busy_Out      <= (state_nxt != S_IDLE);
      if (load_out) begin
        Out_Data_Out <= capture_nxt;
      end
    end
  end

`ifdef SISO_XFER_LOOPBACK_CHECK_EN
  // flags a returned word that differs from the one sent; cleared by the output handshake
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      Mismatch_Out <= 1'b0;
    end else if (load_out) begin
      Mismatch_Out <= (capture_nxt != word);
    end else if (hs_done) begin
      Mismatch_Out <= 1'b0;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = hs_done;
`endif

endmodule

// File: tb/tb_siso_word_transfer_controller.sv
// Self-checking bench: controller plus a behavioural 32-bit SISO, scoreboard of expected words and latencies.
// Define SISO_XFER_LOOPBACK_CHECK_EN to also exercise Mismatch_Out.
module tb_siso_word_transfer_controller;

  localparam int unsigned DW  = 32;
  localparam int          LAT = 2 * DW;

  typedef struct {
    logic [DW-1:0] d;
    int            acc;
    int            lat;
    logic          mm;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          siso_shift;
  logic          siso_dout;
  logic          siso_tap;
  logic          busy;
  logic          tie_zero;
  logic [DW-1:0] siso_q = '0;
`ifdef SISO_XFER_LOOPBACK_CHECK_EN
  logic          mismatch;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   acc;
  int   n;
  logic prev_valid = 1'b0;
  logic [DW-1:0] held;
  exp_t exp_q[$];

  siso_word_transfer_controller #(.DATA_WIDTH(DW)) dut (
    .Clk_In        (clk),
    .Reset_In      (rst),
    .Enable_In     (en),
    .In_Valid_In   (in_valid),
    .In_Data_In    (in_data),
    .In_Ready_Out  (in_ready),
    .Out_Valid_Out (out_valid),
    .Out_Data_Out  (out_data),
    .Out_Ready_In  (out_ready),
    .Siso_Shift_Out(siso_shift),
    .Siso_Data_Out (siso_dout),
    .Siso_Data_In  (siso_tap),
    .Busy_Out      (busy)
`ifdef SISO_XFER_LOOPBACK_CHECK_EN
    ,
    .Mismatch_Out  (mismatch)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural SISO: shifts toward the MSB, serial output is the MSB stage
  always @(posedge clk) if (siso_shift) siso_q <= {siso_q[DW-2:0], siso_dout};
  assign siso_tap = tie_zero ? 1'b0 : siso_q[DW-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic [DW-1:0] exp_d,
                           input int lat, input logic mm, output int acc_cyc);
    int k;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      if (in_ready && en) break;
      k++;
      if (k > 500) begin
        check("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc + 1;
    e.d = exp_d; e.acc = acc_cyc; e.lat = lat; e.mm = mm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // output monitor: latency on valid rise, hold while valid, data at handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        held = out_data;
        if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else check("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
      end else if (out_valid) begin
        check("data_hold", out_data, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          check("out_data", out_data, exp_q[0].d);
`ifdef SISO_XFER_LOOPBACK_CHECK_EN
          check("mismatch", 32'(mismatch), 32'(exp_q[0].mm));
`endif
          void'(exp_q.pop_front());
        end
        last_hs = cyc + 1;
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; tie_zero = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_shift", 32'(siso_shift), 32'd0);
    check("rst_sdata", 32'(siso_dout), 32'd0);
    rst = 1'b0;
    tick();

    // single word, ready drops after acceptance
    push_word(32'hA5A5_0F0F, 32'hA5A5_0F0F, LAT, 1'b0, acc);
    check("t1_ready_drop", 32'(in_ready), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_shift", 32'(siso_shift), 32'd1);
    check("t1_sdata_msb", 32'(siso_dout), 32'd1);
    wait_drain();

    // back-to-back words, second accepted one cycle after the first handshake
    push_word(32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 1'b0, acc);
    push_word(32'h0000_0001, 32'h0000_0001, LAT, 1'b0, acc);
    check("t2_gap", 32'(acc - last_hs), 32'd1);
    wait_drain();

    // consumer stall in DONE
    out_ready = 1'b0;
    push_word(32'hDEAD_BEEF, 32'hDEAD_BEEF, LAT, 1'b0, acc);
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    check("t3_valid_seen", 32'(out_valid), 32'd1);
    repeat (10) begin
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain();

    // enable low for 5 cycles at FILL bit 7
    push_word(32'hC3C3_5A5A, 32'hC3C3_5A5A, LAT + 5, 1'b0, acc);
    repeat (7) tick();
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_shift_frozen", 32'(siso_shift), 32'd0);
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    wait_drain();

    // reset at FLUSH bit 10 discards the word
    push_word(32'h0F0F_F0F0, 32'h0F0F_F0F0, LAT, 1'b0, acc);
    repeat (42) tick();
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t5_ready", 32'(in_ready), 32'd1);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_shift", 32'(siso_shift), 32'd0);
    push_word(32'h1357_9BDF, 32'h1357_9BDF, LAT, 1'b0, acc);
    wait_drain();

    // a few random words
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] r;
      r = $urandom;
      push_word(r, r, LAT, 1'b0, acc);
    end
    wait_drain();

`ifdef SISO_XFER_LOOPBACK_CHECK_EN
    tie_zero = 1'b1;
    push_word(32'h8000_0000, 32'h0000_0000, LAT, 1'b1, acc);
    wait_drain();
    tie_zero = 1'b0;
    check("t6_mm_clear", 32'(mismatch), 32'd0);
    push_word(32'h1234_5678, 32'h1234_5678, LAT, 1'b0, acc);
    wait_drain();
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
